spray_arbiter: RTL and testbench
================================

SPRAY_ARBITER -- requirements
Module: spray_arbiter

Interface
REQ-001 Parameter SPRAY_LEN_W, default 8, width of spray_len and of the internal spray timer.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 token0  input  1  bay 0 coin/token pulse, sampled every clk edge; one credit per high cycle.
REQ-005 token1  input  1  bay 1 coin/token pulse, same rules as token0.
REQ-006 spray_len  input  SPRAY_LEN_W  spray duration in cycles, sampled only in CLEAR.
REQ-007 clrt  output  1  clear-timer strobe, high for exactly the CLEAR cycle.
REQ-008 spray  output  1  shared sprayer enable, high throughout SPRAY.
REQ-009 grant0, grant1  output  1 each  bay served; one-hot during CLEAR and SPRAY, both 0 in IDLE.
REQ-010 drop0, drop1  output  1 each  one-cycle pulse the cycle after a token is discarded due to saturation.

Function
REQ-011 The block SHALL share one sprayer and one internal down-counter timer between two bays.
REQ-012 Each bay SHALL hold a 2-bit credit counter, saturating at 3.
REQ-013 A token while credit < 3 SHALL increment that credit; a token at credit = 3 SHALL be discarded and raise dropN next cycle.
REQ-014 Token and grant-decrement in the same cycle on the same bay SHALL leave credit unchanged and SHALL NOT count as a drop.
REQ-015 FSM states SHALL be IDLE, CLEAR and SPRAY; all outputs except dropN SHALL be Moore functions of state and the grant register.
REQ-016 IDLE: if any credit > 0, go to CLEAR next cycle, latch granted bay, decrement its credit; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both credits > 0, grant the bay not served last; with one, grant that bay.
REQ-018 CLEAR: lasts exactly 1 cycle; clrt = 1; timer loaded with spray_len (value 0 treated as 1); always go to SPRAY.
REQ-019 SPRAY: spray = 1 for exactly the loaded count of cycles; timer decrements once per cycle.
REQ-020 At the last SPRAY cycle, if any credit > 0 (including a token arriving that cycle), arbitrate per REQ-017 and go directly to CLEAR; otherwise go to IDLE.
REQ-021 A token arriving in the same cycle IDLE evaluates SHALL NOT be granted that cycle; it is granted on the following evaluation.
REQ-022 Changes to spray_len outside CLEAR SHALL NOT affect the spray in progress.

Reset
REQ-023 reset SHALL override all other inputs, including a token in the same cycle.
REQ-024 On reset: state IDLE, both credits 0, timer 0, clrt = spray = grant0 = grant1 = drop0 = drop1 = 0.
REQ-025 On reset, last-served SHALL be bay 1, so bay 0 wins the first tie.
REQ-026 Reset asserted mid-CLEAR or mid-SPRAY SHALL end the spray and drop spray to 0 the cycle after the reset edge; queued credits are lost.

Configuration
REQ-027 Macro SPRAY_ARB_ABORT_EN SHALL control the abort feature.
REQ-028 Defined: adds input abort (1 bit); abort high in CLEAR or SPRAY forces IDLE next cycle; consumed credit is not restored; other bay's credit is kept; abort in IDLE is ignored.
REQ-029 Undefined: no abort port; behaviour exactly as REQ-011..REQ-026.

Verification
REQ-030 Reset, then single token0 pulse, spray_len = 4 -> clrt high for 1 cycle with grant0 = 1, then spray high for exactly 4 cycles, then IDLE with all outputs 0.
REQ-031 token0 and token1 in the same cycle after reset, spray_len = 2 -> bay 0 served first, then CLEAR/grant1 immediately after bay 0's last spray cycle with no IDLE gap.
REQ-032 Five token1 pulses in consecutive cycles while bay 1 is spraying -> credit1 saturates at 3; drop1 pulses on each discarded token; three further bay-1 sprays follow.
REQ-033 spray_len = 0 -> spray high for exactly 1 cycle; spray_len changed from 3 to 7 mid-SPRAY -> current spray stays 3 cycles.
REQ-034 reset asserted on the 2nd cycle of a 6-cycle spray with credit0 = 2 -> spray = 0 the next cycle; credits 0; no further grants without new tokens.
REQ-035 With SPRAY_ARB_ABORT_EN: abort on the 1st SPRAY cycle with credit1 = 1 pending -> IDLE for one cycle, then CLEAR with grant1.

Source files
------------

// File: rtl/spray_arbiter.sv
// Two-bay car-wash sprayer arbiter: per-bay saturating credits, round-robin grant, shared spray timer.
// Optional abort input enabled by defining SPRAY_ARB_ABORT_EN.
module spray_arbiter #(
   parameter int SPRAY_LEN_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   token0,
   input  logic                   token1,
   input  logic [SPRAY_LEN_W-1:0] spray_len,
`ifdef SPRAY_ARB_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   clrt,
   output logic                   spray,
   output logic                   grant0,
   output logic                   grant1,
   output logic                   drop0,
   output logic                   drop1
);

   typedef enum logic [1:0] {IDLE, CLEAR, SPRAY} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             cred0_q, cred0_d, cred1_q, cred1_d;
   logic [SPRAY_LEN_W-1:0] timer_q, timer_d;
   logic [1:0]             grant_q, grant_d;
   logic                   last_q, last_d;
   logic                   drop0_q, drop0_d, drop1_q, drop1_d;
   logic                   avail0, avail1, arb, pick, dec0, dec1, inc0, inc1, abort_hit;

`ifdef SPRAY_ARB_ABORT_EN
   assign abort_hit = abort && (state_q != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      grant_d = grant_q;
      last_d  = last_q;
      avail0  = (cred0_q != 2'd0);
      avail1  = (cred1_q != 2'd0);
      arb     = 1'b0;
      pick    = 1'b0;
      dec0    = 1'b0;
      dec1    = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = 2'b00;
            arb     = avail0 | avail1;
         end
         CLEAR: begin
            timer_d = (spray_len == '0) ? SPRAY_LEN_W'(1) : spray_len;
            state_d = SPRAY;
         end
         SPRAY: begin
            timer_d = timer_q - SPRAY_LEN_W'(1);
            if (timer_q <= SPRAY_LEN_W'(1)) begin
               // back-to-back service also sees tokens landing on the final spray cycle
               avail0 = avail0 | token0;
               avail1 = avail1 | token1;
               arb    = avail0 | avail1;
               if (!arb) begin
                  state_d = IDLE;
                  grant_d = 2'b00;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (arb) begin
         pick    = (avail0 && avail1) ? ~last_q : avail1;
         state_d = CLEAR;
         grant_d = pick ? 2'b10 : 2'b01;
         last_d  = pick;
         dec0    = ~pick;
         dec1    = pick;
      end
      if (abort_hit) begin
         state_d = IDLE;
         grant_d = 2'b00;
         last_d  = last_q;
         dec0    = 1'b0;
         dec1    = 1'b0;
      end
   end

   // a token coinciding with a decrement is absorbed, never dropped
   always_comb begin
      inc0    = token0 && ((cred0_q != 2'd3) || dec0);
      inc1    = token1 && ((cred1_q != 2'd3) || dec1);
      drop0_d = token0 && (cred0_q == 2'd3) && !dec0;
      drop1_d = token1 && (cred1_q == 2'd3) && !dec1;
      cred0_d = cred0_q;
      cred1_d = cred1_q;
      if (inc0 && !dec0) cred0_d = cred0_q + 2'd1;
      if (dec0 && !inc0) cred0_d = cred0_q - 2'd1;
      if (inc1 && !dec1) cred1_d = cred1_q + 2'd1;
      if (dec1 && !inc1) cred1_d = cred1_q - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cred0_q <= 2'd0;
         cred1_q <= 2'd0;
         timer_q <= '0;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
         drop0_q <= 1'b0;
         drop1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cred0_q <= cred0_d;
         cred1_q <= cred1_d;
         timer_q <= timer_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         drop0_q <= drop0_d;
         drop1_q <= drop1_d;
      end
   end

   assign clrt   = (state_q == CLEAR);
   assign spray  = (state_q == SPRAY);
   assign grant0 = grant_q[0];
   assign grant1 = grant_q[1];
   assign drop0  = drop0_q;
   assign drop1  = drop1_q;

endmodule

// File: tb/tb_spray_arbiter.sv
// Directed bench for spray_arbiter; outputs packed as {clrt,spray,grant0,grant1,drop0,drop1}.
module tb_spray_arbiter;

   localparam logic [5:0] IDL  = 6'b000000;
   localparam logic [5:0] CLR0 = 6'b101000;
   localparam logic [5:0] SPR0 = 6'b011000;
   localparam logic [5:0] CLR1 = 6'b100100;
   localparam logic [5:0] SPR1 = 6'b010100;
   localparam logic [5:0] DRP0 = 6'b000010;
   localparam logic [5:0] DRP1 = 6'b000001;

   logic       clk, reset, token0, token1;
   logic [7:0] spray_len;
`ifdef SPRAY_ARB_ABORT_EN
   logic       abort;
`endif
   logic       clrt, spray, grant0, grant1, drop0, drop1;
   logic [5:0] obs, exp_v;
   int         checks, failures;

   assign obs = {clrt, spray, grant0, grant1, drop0, drop1};

   spray_arbiter #(.SPRAY_LEN_W(8)) dut (
      .clk(clk), .reset(reset), .token0(token0), .token1(token1), .spray_len(spray_len),
`ifdef SPRAY_ARB_ABORT_EN
      .abort(abort),
`endif
      .clrt(clrt), .spray(spray), .grant0(grant0), .grant1(grant1), .drop0(drop0), .drop1(drop1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; token0 = 1'b0; token1 = 1'b0;
`ifdef SPRAY_ARB_ABORT_EN
      abort = 1'b0;
`endif
      tick; tick;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; token0 = 1'b1; token1 = 1'b1; spray_len = 8'd4;
      tick;
      checks++;
      if (obs !== IDL) begin failures++; $display("FAIL reset_hold got=%b exp=%b", obs, IDL); end
      tick;
      reset = 1'b0; token0 = 1'b0; token1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (obs !== IDL) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, IDL); end
      end
   endtask

   task automatic test_single;
      do_reset; spray_len = 8'd4; token0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (i == 0) token0 = 1'b0;
         exp_v = (i == 1) ? CLR0 : (i >= 2 && i <= 5) ? SPR0 : IDL;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL single cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
   endtask

   task automatic test_tie;
      do_reset; spray_len = 8'd2; token0 = 1'b1; token1 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick;
         if (i == 0) begin token0 = 1'b0; token1 = 1'b0; end
         exp_v = (i == 1) ? CLR0 : (i == 2 || i == 3) ? SPR0 :
                 (i == 4) ? CLR1 : (i == 5 || i == 6) ? SPR1 : IDL;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL tie cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
   endtask

   task automatic test_saturate;
      do_reset; spray_len = 8'd8; token1 = 1'b1;
      tick; token1 = 1'b0;
      checks++;
      if (obs !== IDL) begin failures++; $display("FAIL sat_idle got=%b exp=%b", obs, IDL); end
      tick;
      checks++;
      if (obs !== CLR1) begin failures++; $display("FAIL sat_clear got=%b exp=%b", obs, CLR1); end
      tick;
      checks++;
      if (obs !== SPR1) begin failures++; $display("FAIL sat_spray got=%b exp=%b", obs, SPR1); end
      for (int i = 0; i < 5; i++) begin
         token1 = 1'b1;
         tick;
         exp_v = (i >= 3) ? (SPR1 | DRP1) : SPR1;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL sat_tok cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
      token1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if (obs !== SPR1) begin failures++; $display("FAIL sat_tail cyc=%0d got=%b exp=%b", i, obs, SPR1); end
      end
      for (int r = 0; r < 3; r++) begin
         tick;
         checks++;
         if (obs !== CLR1) begin failures++; $display("FAIL sat_rclr round=%0d got=%b exp=%b", r, obs, CLR1); end
         for (int i = 0; i < 8; i++) begin
            tick;
            checks++;
            if (obs !== SPR1) begin failures++; $display("FAIL sat_rspr round=%0d cyc=%0d got=%b exp=%b", r, i, obs, SPR1); end
         end
      end
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if (obs !== IDL) begin failures++; $display("FAIL sat_end cyc=%0d got=%b exp=%b", i, obs, IDL); end
      end
   endtask

   task automatic test_drop0;
      do_reset; spray_len = 8'd8; token0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (i == 4) token0 = 1'b0;
         exp_v = (i == 0) ? IDL : (i == 1) ? CLR0 : (i == 4) ? (SPR0 | DRP0) : SPR0;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL drop0 cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
   endtask

   task automatic test_spray_len;
      do_reset; spray_len = 8'd0; token0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (i == 0) token0 = 1'b0;
         exp_v = (i == 1) ? CLR0 : (i == 2) ? SPR0 : IDL;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL len0 cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
      spray_len = 8'd3; token0 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick;
         if (i == 0) token0 = 1'b0;
         if (i == 2) spray_len = 8'd7;
         exp_v = (i == 1) ? CLR0 : (i >= 2 && i <= 4) ? SPR0 : IDL;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL lenchg cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
   endtask

   task automatic test_reset_mid;
      do_reset; spray_len = 8'd6; token0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i == 2) token0 = 1'b0;
         exp_v = (i == 0) ? IDL : (i == 1) ? CLR0 : SPR0;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL rmid_pre cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      checks++;
      if (obs !== IDL) begin failures++; $display("FAIL rmid_cut got=%b exp=%b", obs, IDL); end
      for (int i = 0; i < 10; i++) begin
         tick;
         checks++;
         if (obs !== IDL) begin failures++; $display("FAIL rmid_post cyc=%0d got=%b exp=%b", i, obs, IDL); end
      end
   endtask

`ifdef SPRAY_ARB_ABORT_EN
   task automatic test_abort;
      do_reset; spray_len = 8'd4; token0 = 1'b1; token1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (i == 0) begin token0 = 1'b0; token1 = 1'b0; end
         if (i == 2) abort = 1'b1;
         if (i == 3) abort = 1'b0;
         exp_v = (i == 1) ? CLR0 : (i == 2) ? SPR0 : (i == 4) ? CLR1 : (i == 5) ? SPR1 : IDL;
         checks++;
         if (obs !== exp_v) begin failures++; $display("FAIL abort cyc=%0d got=%b exp=%b", i, obs, exp_v); end
      end
   endtask
`endif

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; token0 = 1'b0; token1 = 1'b0; spray_len = 8'd0;
`ifdef SPRAY_ARB_ABORT_EN
      abort = 1'b0;
`endif
      test_reset;
      test_single;
      test_tie;
      test_saturate;
      test_drop0;
      test_spray_len;
      test_reset_mid;
`ifdef SPRAY_ARB_ABORT_EN
      test_abort;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
